// File: rtl/jellyvl_etherneco_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// jellyvl_etherneco_cmd_scheduler
//
// Multi-channel command scheduler for the EtherNeco ring master. Each command
// slot runs a free counter with its own period. When the counter wraps, the
// slot becomes pending. Pending slots are granted round-robin, one at a time,
// to the outer-ring packet transmitter. Each issued command is then tracked
// until its response arrives on the inner ring or it times out.
//
// Optional feature macro: ETHERNECO_SCHED_TIMEOUT_EN
//   defined     - WAIT_RES gives up after `timeout` cycles and pulses
//                 cmd_timeout.
//   not defined - WAIT_RES waits for res_rx_end indefinitely, cmd_timeout is
//                 tied to 0 and the timeout port is ignored.
//
// Ports
//   clk, reset      clock; synchronous active-low reset
//   enable          global grant enable (in-flight commands always finish)
//   ch_enable       per-channel enable; deasserting it drops the pending bit
//   ch_period       per-channel period in clk cycles; 0 = never due
//   ch_type/node/length  per-channel packet fields
//   timeout         response timeout in clk cycles; 0 = none
//   tx_start        one-cycle start pulse to the packet transmitter
//   tx_type/node/length/channel  fields of the granted command, held from
//                                grant until the return to IDLE
//   tx_done         packet transmit finished (pulse, only used in TX)
//   res_rx_end/error/type  inner-ring response (only used in WAIT_RES)
//   busy            state is not IDLE
//   pending         due-but-not-granted flags
//   cmd_done/cmd_error/cmd_timeout  completion pulses
//   cmd_channel     channel of the most recent completion
//   overrun_count   saturating count of periods that expired while the
//                   channel was still pending
// ---------------------------------------------------------------------------
module jellyvl_etherneco_cmd_scheduler #(
  parameter int CHANNELS      = 4,
  parameter int PERIOD_WIDTH  = 16,
  parameter int TIMEOUT_WIDTH = 16,
  localparam int CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [CHANNELS-1:0]            ch_enable,
  input  logic [CHANNELS*PERIOD_WIDTH-1:0] ch_period,
  input  logic [CHANNELS*8-1:0]          ch_type,
  input  logic [CHANNELS*8-1:0]          ch_node,
  input  logic [CHANNELS*16-1:0]         ch_length,
  input  logic [TIMEOUT_WIDTH-1:0]       timeout,
  output logic                           tx_start,
  output logic [7:0]                     tx_type,
  output logic [7:0]                     tx_node,
  output logic [15:0]                    tx_length,
  output logic [CH_BITS-1:0]             tx_channel,
  input  logic                           tx_done,
  input  logic                           res_rx_end,
  input  logic                           res_rx_error,
  input  logic [7:0]                     res_rx_type,
  output logic                           busy,
  output logic [CHANNELS-1:0]            pending,
  output logic                           cmd_done,
  output logic                           cmd_error,
  output logic                           cmd_timeout,
  output logic [CH_BITS-1:0]             cmd_channel,
  output logic [15:0]                    overrun_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_TX,
    ST_WAIT_RES
  } state_t;

  state_t                  state;
  state_t                  next_state;

  logic [CH_BITS-1:0]      rr_ptr;
  logic [PERIOD_WIDTH-1:0] cnt [CHANNELS];
  logic [CHANNELS-1:0]     wrap;
  logic [CHANNELS-1:0]     pending_next;
  logic [4:0]              overrun_inc;
  logic [16:0]             overrun_sum;

  logic                    grant_valid;
  logic [CH_BITS-1:0]      grant_idx;
  int                      scan_idx;
  logic [CH_BITS-1:0]      scan_ch;

  logic                    grant_fire;
  logic                    done_fire;
  logic                    error_fire;

`ifdef ETHERNECO_SCHED_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wait_cnt;
  logic                     timeout_fire;
`else
  logic                     unused_timeout;
  assign unused_timeout = ^timeout;
`endif

  // A channel wraps on the cycle its counter reaches period-1. The >= keeps
  // the channel from running away if the period is lowered below the count.
  always_comb begin
    wrap = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wrap[i] = ch_enable[i]
             && (ch_period[i*PERIOD_WIDTH +: PERIOD_WIDTH] != '0)
             && (cnt[i] >= ch_period[i*PERIOD_WIDTH +: PERIOD_WIDTH] - PERIOD_WIDTH'(1));
    end
  end

  // Round-robin search: scan offsets from the highest down to zero, so the
  // pending channel closest to rr_ptr (searching upward, wrapping) is the
  // one left selected.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    scan_ch     = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= CHANNELS) begin
        scan_idx = scan_idx - CHANNELS;
      end
      scan_ch = CH_BITS'(scan_idx);
      if (pending[scan_ch]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_ch;
      end
    end
  end

  // Pending bit update. A wrap in the same cycle as the grant of that
  // channel re-arms it without counting an overrun, since the old request
  // is being served right now.
  always_comb begin
    pending_next = pending;
    overrun_inc  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!ch_enable[i]) begin
        pending_next[i] = 1'b0;
      end else if (wrap[i]) begin
        pending_next[i] = 1'b1;
        if (pending[i] && !(grant_fire && (grant_idx == CH_BITS'(i)))) begin
          overrun_inc = overrun_inc + 5'd1;
        end
      end else if (grant_fire && (grant_idx == CH_BITS'(i))) begin
        pending_next[i] = 1'b0;
      end
    end
    overrun_sum = {1'b0, overrun_count} + 17'(overrun_inc);
  end

  // Next-state logic. Completion conditions are decoded here and registered
  // below so every output comes straight from a flop.
  always_comb begin
    next_state = state;
    grant_fire = 1'b0;
    done_fire  = 1'b0;
    error_fire = 1'b0;
`ifdef ETHERNECO_SCHED_TIMEOUT_EN
    timeout_fire = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (enable && grant_valid) begin
          grant_fire = 1'b1;
          next_state = ST_START;
        end
      end
      ST_START: begin
        next_state = ST_TX;
      end
      ST_TX: begin
        if (tx_done) begin
          next_state = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        if (res_rx_end) begin
          if (res_rx_error || (res_rx_type != tx_type)) begin
            error_fire = 1'b1;
          end else begin
            done_fire = 1'b1;
          end
          next_state = ST_IDLE;
        end
`ifdef ETHERNECO_SCHED_TIMEOUT_EN
        // wait_cnt is 0 in the first WAIT_RES cycle, so comparing the
        // incremented value lands the registered pulse exactly `timeout`
        // cycles after entry.
        else if ((timeout != '0) && ((wait_cnt + TIMEOUT_WIDTH'(1)) == timeout)) begin
          timeout_fire = 1'b1;
          next_state   = ST_IDLE;
        end
`endif
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Per-channel period counters, pending flags and the overrun counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
      pending       <= '0;
      overrun_count <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!ch_enable[i] || (ch_period[i*PERIOD_WIDTH +: PERIOD_WIDTH] == '0)) begin
          cnt[i] <= '0;
        end else if (wrap[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + PERIOD_WIDTH'(1);
        end
      end
      pending       <= pending_next;
      overrun_count <= overrun_sum[16] ? 16'hFFFF : overrun_sum[15:0];
    end
  end

  // State register, grant latch and registered status/pulse outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      tx_start    <= 1'b0;
      tx_type     <= '0;
      tx_node     <= '0;
      tx_length   <= '0;
      tx_channel  <= '0;
      busy        <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_error   <= 1'b0;
      cmd_channel <= '0;
    end else begin
      state     <= next_state;
      busy      <= (next_state != ST_IDLE);
      tx_start  <= grant_fire;
      cmd_done  <= done_fire;
      cmd_error <= error_fire;
      if (grant_fire) begin
        tx_type    <= ch_type[int'(grant_idx)*8 +: 8];
        tx_node    <= ch_node[int'(grant_idx)*8 +: 8];
        tx_length  <= ch_length[int'(grant_idx)*16 +: 16];
        tx_channel <= grant_idx;
        rr_ptr     <= (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + CH_BITS'(1);
      end
`ifdef ETHERNECO_SCHED_TIMEOUT_EN
      if (done_fire || error_fire || timeout_fire) begin
`else
      if (done_fire || error_fire) begin
`endif
        cmd_channel <= tx_channel;
      end
    end
  end

`ifdef ETHERNECO_SCHED_TIMEOUT_EN
  // Response wait counter: zero on the first WAIT_RES cycle, counting up
  // while the response is outstanding.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt    <= '0;
      cmd_timeout <= 1'b0;
    end else begin
      cmd_timeout <= timeout_fire;
      if (state != ST_WAIT_RES) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
      end
    end
  end
`else
  assign cmd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_jellyvl_etherneco_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_jellyvl_etherneco_cmd_scheduler
//
// Directed bench for the command scheduler with CHANNELS=4. Inputs change on
// the falling edge, outputs are read on the falling edge after each rising
// edge. Cycle counts in the comments are rising edges since the
// configuration step.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jellyvl_etherneco_cmd_scheduler;

  localparam int CHANNELS = 4;
  localparam int PW       = 16;
  localparam int TW       = 16;
  localparam int CB       = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [CHANNELS-1:0]  ch_enable;
  logic [CHANNELS*PW-1:0] ch_period;
  logic [CHANNELS*8-1:0]  ch_type;
  logic [CHANNELS*8-1:0]  ch_node;
  logic [CHANNELS*16-1:0] ch_length;
  logic [TW-1:0]        timeout;
  logic                 tx_start;
  logic [7:0]           tx_type;
  logic [7:0]           tx_node;
  logic [15:0]          tx_length;
  logic [CB-1:0]        tx_channel;
  logic                 tx_done;
  logic                 res_rx_end;
  logic                 res_rx_error;
  logic [7:0]           res_rx_type;
  logic                 busy;
  logic [CHANNELS-1:0]  pending;
  logic                 cmd_done;
  logic                 cmd_error;
  logic                 cmd_timeout;
  logic [CB-1:0]        cmd_channel;
  logic [15:0]          overrun_count;

  int total = 0;
  int bad = 0;
  int steps;
  int doneSeen = 0;
  int startSeen = 0;
  int mark;

  always #5 clk = ~clk;

  jellyvl_etherneco_cmd_scheduler #(
    .CHANNELS      (CHANNELS),
    .PERIOD_WIDTH  (PW),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .ch_enable     (ch_enable),
    .ch_period     (ch_period),
    .ch_type       (ch_type),
    .ch_node       (ch_node),
    .ch_length     (ch_length),
    .timeout       (timeout),
    .tx_start      (tx_start),
    .tx_type       (tx_type),
    .tx_node       (tx_node),
    .tx_length     (tx_length),
    .tx_channel    (tx_channel),
    .tx_done       (tx_done),
    .res_rx_end    (res_rx_end),
    .res_rx_error  (res_rx_error),
    .res_rx_type   (res_rx_type),
    .busy          (busy),
    .pending       (pending),
    .cmd_done      (cmd_done),
    .cmd_error     (cmd_error),
    .cmd_timeout   (cmd_timeout),
    .cmd_channel   (cmd_channel),
    .overrun_count (overrun_count)
  );

  // Pulse monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (cmd_done === 1'b1) doneSeen++;
    if (tx_start === 1'b1) startSeen++;
  end

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Steps until tx_start is seen; -1 if the budget runs out.
  task automatic waitStart(input int maxCycles, output int n);
    n = 0;
    do begin
      applyStimulus(1);
      n++;
    end while (tx_start !== 1'b1 && n < maxCycles);
    if (tx_start !== 1'b1) n = -1;
  endtask

  // Called with the DUT in START: one TX cycle with tx_done, `hold` idle
  // cycles in WAIT_RES, then a response on the following edge.
  task automatic runCommand(input logic [7:0] respType, input logic respErr, input int hold);
    applyStimulus(1);
    checkOutput("start_pulse_one_cycle", tx_start, 0);
    tx_done = 1'b1;
    applyStimulus(1);
    tx_done = 1'b0;
    applyStimulus(hold);
    res_rx_end   = 1'b1;
    res_rx_type  = respType;
    res_rx_error = respErr;
    applyStimulus(1);
    res_rx_end   = 1'b0;
    res_rx_type  = 8'h00;
    res_rx_error = 1'b0;
  endtask

  task automatic setPeriod(input int ch, input logic [PW-1:0] val);
    ch_period[ch*PW +: PW] = val;
  endtask

  task automatic clearConfig();
    enable    = 1'b0;
    ch_enable = '0;
    ch_period = '0;
    timeout   = '0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(2);
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    tx_done      = 1'b0;
    res_rx_end   = 1'b0;
    res_rx_error = 1'b0;
    res_rx_type  = 8'h00;
    ch_type      = {8'h13, 8'h12, 8'h11, 8'h10};
    ch_node      = {8'h23, 8'h22, 8'h21, 8'h20};
    ch_length    = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    clearConfig();
    applyStimulus(3);

    // Reset state
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_overrun", overrun_count, 0);
    checkOutput("rst_tx_channel", tx_channel, 0);
    checkOutput("rst_tx_type", tx_type, 0);
    checkOutput("rst_cmd_channel", cmd_channel, 0);
    checkOutput("rst_cmd_done", cmd_done, 0);
    checkOutput("rst_cmd_timeout", cmd_timeout, 0);
    reset = 1'b1;

    // Single channel, period 100: wrap at edge 100, tx_start after edge 101,
    // then every 100 cycles (3 of them spent in runCommand).
    $display("[TB] periodic single channel");
    ch_enable = 4'b0001;
    setPeriod(0, 100);
    enable = 1'b1;
    waitStart(150, steps);
    checkOutput("t1_first_start", steps, 101);
    checkOutput("t1_tx_channel", tx_channel, 0);
    checkOutput("t1_tx_type", tx_type, 8'h10);
    checkOutput("t1_busy", busy, 1);
    runCommand(8'h10, 1'b0, 0);
    checkOutput("t1_cmd_done", cmd_done, 1);
    checkOutput("t1_cmd_channel", cmd_channel, 0);
    checkOutput("t1_idle", busy, 0);
    for (int k = 0; k < 2; k++) begin
      waitStart(150, steps);
      checkOutput("t1_period_start", steps, 97);
      runCommand(8'h10, 1'b0, 0);
      checkOutput("t1_cmd_done_n", cmd_done, 1);
    end
    checkOutput("t1_overrun", overrun_count, 0);

    // Round robin: all four pending at once, period then forced to 0.
    $display("[TB] round robin");
    clearConfig();
    doReset();
    ch_enable = 4'b1111;
    for (int c = 0; c < CHANNELS; c++) setPeriod(c, 20);
    applyStimulus(20);
    checkOutput("t2_all_pending", pending, 4'b1111);
    checkOutput("t2_no_grant_disabled", busy, 0);
    ch_period = '0;
    enable = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      waitStart(10, steps);
      checkOutput("t2_grant_latency", steps, 1);
      checkOutput("t2_grant_order", tx_channel, c);
      checkOutput("t2_tx_type", tx_type, 8'h10 + c);
      checkOutput("t2_tx_node", tx_node, 8'h20 + c);
      checkOutput("t2_tx_length", tx_length, 16'h0100 + c);
      runCommand(8'h10 + 8'(c), 1'b0, 0);
      checkOutput("t2_cmd_channel", cmd_channel, c);
    end
    setPeriod(0, 20);
    setPeriod(2, 20);
    applyStimulus(20);
    checkOutput("t2_repend", pending, 4'b0101);
    ch_period = '0;
    waitStart(10, steps);
    checkOutput("t2_second_a", tx_channel, 0);
    checkOutput("t2_pending_left", pending, 4'b0100);
    runCommand(8'h10, 1'b0, 0);
    waitStart(10, steps);
    checkOutput("t2_second_b", tx_channel, 2);
    runCommand(8'h12, 1'b0, 0);

    // Overrun: ch1 period 10, command cycle of 30 edges gives 2 per command.
    $display("[TB] overrun");
    clearConfig();
    doReset();
    ch_enable = 4'b0010;
    setPeriod(1, 10);
    enable = 1'b1;
    waitStart(20, steps);
    checkOutput("t3_first_start", steps, 11);
    checkOutput("t3_tx_channel", tx_channel, 1);
    runCommand(8'h11, 1'b0, 26);
    checkOutput("t3_cmd_done", cmd_done, 1);
    checkOutput("t3_overrun_1", overrun_count, 2);
    checkOutput("t3_pending_1", pending, 4'b0010);
    waitStart(5, steps);
    checkOutput("t3_regrant", steps, 1);
    runCommand(8'h11, 1'b0, 26);
    checkOutput("t3_overrun_2", overrun_count, 4);
    checkOutput("t3_pending_2", pending, 4'b0010);

    // Saturation: four channels with period 1 overrun 4 per cycle after the
    // first edge; 4*16383 = 0xFFFC, the next edge saturates.
    $display("[TB] overrun saturation");
    clearConfig();
    doReset();
    ch_enable = 4'b1111;
    for (int c = 0; c < CHANNELS; c++) setPeriod(c, 1);
    applyStimulus(16384);
    checkOutput("t3_sat_before", overrun_count, 16'hFFFC);
    applyStimulus(1);
    checkOutput("t3_sat_hit", overrun_count, 16'hFFFF);
    applyStimulus(3);
    checkOutput("t3_sat_hold", overrun_count, 16'hFFFF);
    checkOutput("t3_sat_pending", pending, 4'b1111);

    // Error responses on ch3: type mismatch, then error flag.
    $display("[TB] error responses");
    clearConfig();
    doReset();
    ch_enable = 4'b1000;
    setPeriod(3, 20);
    enable = 1'b1;
    mark = doneSeen;
    waitStart(40, steps);
    checkOutput("t4_first_start", steps, 21);
    checkOutput("t4_tx_channel", tx_channel, 3);
    runCommand(8'h55, 1'b0, 0);
    checkOutput("t4_err_type", cmd_error, 1);
    checkOutput("t4_done_type", cmd_done, 0);
    checkOutput("t4_err_channel", cmd_channel, 3);
    waitStart(40, steps);
    checkOutput("t4_second_start", steps, 17);
    runCommand(8'h13, 1'b1, 0);
    checkOutput("t4_err_flag", cmd_error, 1);
    checkOutput("t4_done_flag", cmd_done, 0);
    applyStimulus(1);
    checkOutput("t4_err_pulse", cmd_error, 0);
    checkOutput("t4_done_never", doneSeen - mark, 0);

    // Response timeout of 50 cycles.
    $display("[TB] timeout");
    clearConfig();
    doReset();
    ch_enable = 4'b0001;
    setPeriod(0, 20);
    timeout = 50;
    enable = 1'b1;
    waitStart(40, steps);
    checkOutput("t5_first_start", steps, 21);
    applyStimulus(1);
    tx_done = 1'b1;
    applyStimulus(1);
    tx_done = 1'b0;
    applyStimulus(49);
    checkOutput("t5_no_timeout_49", cmd_timeout, 0);
    checkOutput("t5_busy_49", busy, 1);
    applyStimulus(1);
`ifdef ETHERNECO_SCHED_TIMEOUT_EN
    checkOutput("t5_timeout_50", cmd_timeout, 1);
    checkOutput("t5_idle_50", busy, 0);
    checkOutput("t5_timeout_done", cmd_done, 0);
    checkOutput("t5_timeout_channel", cmd_channel, 0);
    waitStart(5, steps);
    checkOutput("t5_regrant", steps, 1);
    runCommand(8'h10, 1'b0, 49);
    checkOutput("t5_tie_done", cmd_done, 1);
    checkOutput("t5_tie_timeout", cmd_timeout, 0);
`else
    checkOutput("t5_never_timeout", cmd_timeout, 0);
    checkOutput("t5_still_busy", busy, 1);
    applyStimulus(20);
    checkOutput("t5_still_busy_70", busy, 1);
    res_rx_end  = 1'b1;
    res_rx_type = 8'h10;
    applyStimulus(1);
    res_rx_end  = 1'b0;
    res_rx_type = 8'h00;
    checkOutput("t5_late_done", cmd_done, 1);
`endif

    // Reset in WAIT_RES, then enable dropped during TX.
    $display("[TB] reset and enable");
    clearConfig();
    doReset();
    ch_enable = 4'b0110;
    setPeriod(1, 20);
    setPeriod(2, 20);
    enable = 1'b1;
    waitStart(40, steps);
    checkOutput("t6_first_start", steps, 21);
    checkOutput("t6_tx_channel", tx_channel, 1);
    applyStimulus(1);
    tx_done = 1'b1;
    applyStimulus(1);
    tx_done = 1'b0;
    checkOutput("t6_wait_busy", busy, 1);
    checkOutput("t6_wait_pending", pending, 4'b0100);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_pending", pending, 0);
    checkOutput("t6_rst_tx_start", tx_start, 0);
    checkOutput("t6_rst_done", cmd_done, 0);
    checkOutput("t6_rst_error", cmd_error, 0);
    checkOutput("t6_rst_tx_channel", tx_channel, 0);
    reset = 1'b1;
    waitStart(40, steps);
    checkOutput("t6_restart", steps, 21);
    checkOutput("t6_restart_channel", tx_channel, 1);
    applyStimulus(1);
    enable  = 1'b0;
    tx_done = 1'b1;
    applyStimulus(1);
    tx_done     = 1'b0;
    res_rx_end  = 1'b1;
    res_rx_type = 8'h11;
    applyStimulus(1);
    res_rx_end  = 1'b0;
    res_rx_type = 8'h00;
    checkOutput("t6_complete_disabled", cmd_done, 1);
    mark = startSeen;
    applyStimulus(5);
    checkOutput("t6_held_idle", busy, 0);
    checkOutput("t6_held_pending", pending, 4'b0100);
    applyStimulus(12);
    checkOutput("t6_accumulate", pending, 4'b0110);
    checkOutput("t6_accum_overrun", overrun_count, 1);
    checkOutput("t6_no_start", startSeen - mark, 0);
    enable = 1'b1;
    waitStart(5, steps);
    checkOutput("t6_reenable", steps, 1);
    checkOutput("t6_reenable_channel", tx_channel, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
